// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute stage and the decoder: opcodes, FSM states, widths.
// The MUL state only exists when EXEC_MUL_EN is defined.
package exec_unit_pkg;

    localparam int PKG_XLEN = 16;
    localparam int PKG_RAW  = 3;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef EXEC_MUL_EN
        ST_MUL   = 2'd2,
`endif
        ST_WB    = 2'd3
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU for ops ADD..SLTU; every other opcode yields 0.
module alu_comb
    import exec_unit_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execute unit: issue handshake, serial shifter, optional shift-add multiplier
// (EXEC_MUL_EN) and the register-file write-back port.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int RAW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [3:0]      op,
    input  logic [RAW-1:0]  rd,
    input  logic [XLEN-1:0] src1_dat,
    input  logic [XLEN-1:0] src2_dat,
    output logic            wb_we,
    output logic [RAW-1:0]  wb_tgt,
    output logic [XLEN-1:0] wb_dat,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [RAW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wb_we_q, wb_we_d;
    logic [RAW-1:0]  wb_tgt_q, wb_tgt_d;
    logic [XLEN-1:0] wb_dat_q, wb_dat_d;
`ifdef EXEC_MUL_EN
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] acc_next;
`endif

    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] sh_next;
    logic [3:0]      shamt;
    logic            issue_fire;

    alu_comb #(
        .XLEN (XLEN)
    ) u_alu (
        .op (op),
        .a  (src1_dat),
        .b  (src2_dat),
        .y  (alu_y)
    );

    assign shamt       = src2_dat[3:0];
    assign issue_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign issue_fire  = issue_valid && issue_ready;
`ifdef EXEC_MUL_EN
    assign busy        = (state_q == ST_SHIFT) || (state_q == ST_MUL);
    assign acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign busy        = (state_q == ST_SHIFT);
`endif

    assign wb_we  = wb_we_q;
    assign wb_tgt = wb_tgt_q;
    assign wb_dat = wb_dat_q;

    // One-bit step of the serial shifter; SRA refills with the sign bit.
    always_comb begin
        sh_next = sh_q;
        case (op_q)
            OP_SLL:  sh_next = sh_q << 1;
            OP_SRL:  sh_next = sh_q >> 1;
            default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        wb_we_d  = 1'b0;
        wb_tgt_d = wb_tgt_q;
        wb_dat_d = wb_dat_q;
`ifdef EXEC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif

        case (state_q)
            ST_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = ST_WB;
                    wb_dat_d = sh_next;
                    wb_tgt_d = rd_q;
                    wb_we_d  = (rd_q != '0);
                end
            end
`ifdef EXEC_MUL_EN
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                // Counter wrapping 15 -> 0 marks the sixteenth partial product.
                if (cnt_q == 4'd15) begin
                    state_d  = ST_WB;
                    wb_dat_d = acc_next;
                    wb_tgt_d = rd_q;
                    wb_we_d  = (rd_q != '0);
                end
            end
`endif
            default: ;
        endcase

        if (issue_fire) begin
            op_d = op;
            rd_d = rd;
            if (is_shift(op) && (shamt != 4'd0)) begin
                state_d = ST_SHIFT;
                sh_d    = src1_dat;
                cnt_d   = shamt;
            end else if (is_shift(op)) begin
                state_d  = ST_WB;
                wb_dat_d = src1_dat;
                wb_tgt_d = rd;
                wb_we_d  = (rd != '0);
`ifdef EXEC_MUL_EN
            end else if (op == OP_MUL) begin
                state_d  = ST_MUL;
                cnt_d    = 4'd0;
                acc_d    = '0;
                mcand_d  = src1_dat;
                mplier_d = src2_dat;
`endif
            end else begin
                state_d  = ST_WB;
                wb_dat_d = alu_y;
                wb_tgt_d = rd;
                wb_we_d  = (rd != '0);
            end
        end else if (state_q == ST_WB) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            wb_we_q  <= 1'b0;
            wb_tgt_q <= '0;
            wb_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_we_q  <= wb_we_d;
            wb_tgt_q <= wb_tgt_d;
            wb_dat_q <= wb_dat_d;
        end
    end

    // Operand/working registers are only meaningful while the FSM is active.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        rd_q <= rd_d;
        sh_q <= sh_d;
`ifdef EXEC_MUL_EN
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
`endif
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: vector table, scoreboard of expected write-backs,
// and hand sequences for shift timing, back-to-back issue and reset mid-operation.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] src1_dat;
    logic [15:0] src2_dat;
    logic        wb_we;
    logic [2:0]  wb_tgt;
    logic [15:0] wb_dat;
    logic        busy;

    exec_unit #(.XLEN(16), .RAW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .op          (op),
        .rd          (rd),
        .src1_dat    (src1_dat),
        .src2_dat    (src2_dat),
        .wb_we       (wb_we),
        .wb_tgt      (wb_tgt),
        .wb_dat      (wb_dat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        logic [2:0]  tgt;
        logic [15:0] dat;
        logic        we;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    function automatic int lat_of(input logic [3:0] o, input logic [15:0] b);
        if (o == 4'd7 || o == 4'd8 || o == 4'd9)
            return (b[3:0] == 4'd0) ? 1 : int'(b[3:0]) + 1;
`ifdef EXEC_MUL_EN
        if (o == 4'd10) return 17;
`endif
        return 1;
    endfunction

    function automatic logic [15:0] model(input logic [3:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb_v;
        logic [31:0]        p;
        sa   = a;
        sb_v = b;
        p    = 32'(a) * 32'(b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb_v) ? 16'd1 : 16'd0;
            4'd6:  return (a < b) ? 16'd1 : 16'd0;
            4'd7:  return a << b[3:0];
            4'd8:  return a >> b[3:0];
            4'd9:  return sa >>> b[3:0];
`ifdef EXEC_MUL_EN
            4'd10: return p[15:0];
`endif
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write-back monitor: every WB cycle must match the queue head at its due cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL wb_missed: due cycle %0d, now %0d", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            n_chk++;
            if (wb_we !== sb[0].we || wb_tgt !== sb[0].tgt || wb_dat !== sb[0].dat) begin
                n_fail++;
                $display("FAIL wb_result: got we=%b tgt=%0d dat=%h, expected we=%b tgt=%0d dat=%h",
                         wb_we, wb_tgt, wb_dat, sb[0].we, sb[0].tgt, sb[0].dat);
            end
            void'(sb.pop_front());
        end else if (wb_we !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_wb: got we=%b tgt=%0d dat=%h at cycle %0d, expected we=0",
                     wb_we, wb_tgt, wb_dat, cyc);
        end
    end

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic do_issue(input logic [3:0] o, input logic [2:0] r, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] e, input bit push);
        int n = 0;
        issue_valid = 1'b1;
        op          = o;
        rd          = r;
        src1_dat    = a;
        src2_dat    = b;
        while (!issue_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!issue_ready) begin
            chk("issue_timeout", 32'(issue_ready), 32'd1);
            issue_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{cyc + lat_of(o, b), r, e, (r != 3'd0)});
        @(negedge clk);
        issue_valid = 1'b0;
        src1_dat    = $urandom();
        src2_dat    = $urandom();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs.push_back('{4'd0,  3'd3, 16'h7FFF, 16'h0001, 16'h8000});
        vecs.push_back('{4'd1,  3'd1, 16'h0000, 16'h0001, 16'hFFFF});
        vecs.push_back('{4'd2,  3'd2, 16'hF0F0, 16'hFF00, 16'hF000});
        vecs.push_back('{4'd3,  3'd4, 16'h1200, 16'h0034, 16'h1234});
        vecs.push_back('{4'd4,  3'd6, 16'hAAAA, 16'hFFFF, 16'h5555});
        vecs.push_back('{4'd5,  3'd1, 16'h8000, 16'h0001, 16'h0001});
        vecs.push_back('{4'd6,  3'd2, 16'h8000, 16'h0001, 16'h0000});
        vecs.push_back('{4'd7,  3'd3, 16'h0001, 16'h000F, 16'h8000});
        vecs.push_back('{4'd8,  3'd4, 16'h8000, 16'h0004, 16'h0800});
        vecs.push_back('{4'd9,  3'd5, 16'h8000, 16'h0004, 16'hF800});
        vecs.push_back('{4'd7,  3'd6, 16'h1234, 16'h0010, 16'h1234});
        vecs.push_back('{4'd11, 3'd7, 16'hFFFF, 16'hFFFF, 16'h0000});
        vecs.push_back('{4'd15, 3'd1, 16'h1234, 16'h5678, 16'h0000});
        vecs.push_back('{4'd0,  3'd2, 16'hFFFF, 16'h0002, 16'h0001});
        vecs.push_back('{4'd9,  3'd1, 16'h7FF0, 16'h0003, 16'h0FFE});
        vecs.push_back('{4'd6,  3'd0, 16'h0001, 16'hFFFF, 16'h0001});
`ifdef EXEC_MUL_EN
        vecs.push_back('{4'd10, 3'd7, 16'h0123, 16'h0010, 16'h1230});
        vecs.push_back('{4'd10, 3'd3, 16'hFFFF, 16'hFFFF, 16'h0001});
`else
        vecs.push_back('{4'd10, 3'd7, 16'h0123, 16'h0010, 16'h0000});
        vecs.push_back('{4'd10, 3'd3, 16'hFFFF, 16'hFFFF, 16'h0000});
`endif

        rst         = 1'b1;
        issue_valid = 1'b0;
        op          = 4'd0;
        rd          = 3'd0;
        src1_dat    = 16'd0;
        src2_dat    = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_wb_we",  32'(wb_we),  32'd0);
        chk("reset_wb_dat", 32'(wb_dat), 32'd0);
        chk("reset_wb_tgt", 32'(wb_tgt), 32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(issue_ready), 32'd1);

        foreach (vecs[i]) begin
            do_issue(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            drain();
        end

        // SRA by 4: four busy cycles, then WB.
        do_issue(4'd9, 3'd5, 16'h8000, 16'h0004, 16'hF800, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("sra_busy",      32'(busy),        32'd1);
            chk("sra_not_ready", 32'(issue_ready), 32'd0);
            @(negedge clk);
        end
        chk("sra_wb_ready", 32'(issue_ready), 32'd1);
        chk("sra_wb_busy",  32'(busy),        32'd0);
        drain();

        // Back-to-back issue; the scoreboard due cycles force consecutive WBs.
        do_issue(4'd4, 3'd1, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b1);
        do_issue(4'd3, 3'd2, 16'h0001, 16'h0002, 16'h0003, 1'b1);
        do_issue(4'd8, 3'd3, 16'hF000, 16'h0002, 16'h3C00, 1'b1);
        do_issue(4'd0, 3'd4, 16'h0010, 16'h0020, 16'h0030, 1'b1);
        drain();

        for (int k = 0; k < 24; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom());
            rb = 16'($urandom());
            do_issue(ro, 3'($urandom_range(0, 7)), ra, rb, model(ro, ra, rb), 1'b1);
        end
        drain();

        // Reset during a long operation: nothing may be written back.
        do_issue(4'd0, 3'd3, 16'h1111, 16'h2222, 16'h3333, 1'b1);
        drain();
`ifdef EXEC_MUL_EN
        do_issue(4'd10, 3'd7, 16'h0123, 16'h0010, 16'h0000, 1'b0);
`else
        do_issue(4'd7, 3'd7, 16'h0123, 16'h000F, 16'h0000, 1'b0);
`endif
        repeat (8) @(negedge clk);
        chk("midop_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_rst_we",    32'(wb_we),       32'd0);
        chk("midop_rst_dat",   32'(wb_dat),      32'd0);
        chk("midop_rst_tgt",   32'(wb_tgt),      32'd0);
        chk("midop_rst_busy",  32'(busy),        32'd0);
        chk("midop_rst_ready", 32'(issue_ready), 32'd1);
        repeat (20) @(negedge clk);

        do_issue(4'd1, 3'd6, 16'h0100, 16'h0001, 16'h00FF, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 16, datapath width; only 16 is supported.
REQ-002 SHALL have parameter RAW, default 3, register-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port issue_valid, input, 1, the operation below is presented.
REQ-006 SHALL have port issue_ready, output, 1, the unit can accept an operation this cycle.
REQ-007 SHALL have port op, input, 4, operation code (see REQ-012).
REQ-008 SHALL have port rd, input, RAW, destination register index.
REQ-009 SHALL have ports src1_dat and src2_dat, input, XLEN each, operands read from the register file.
REQ-010 SHALL have ports wb_we (output, 1), wb_tgt (output, RAW) and wb_dat (output, XLEN), which drive the register-file write port (we/tgt/tgt_dat).
REQ-011 SHALL have port busy, output, 1, a multi-cycle operation is in progress.

Function
REQ-012 Opcode map SHALL be:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
- 5 SLT (signed), 6 SLTU (unsigned); both produce 1 or 0;
- 7 SLL, 8 SRL, 9 SRA;
- 10 MUL (low 16 bits of the product);
- 11-15 undefined.
REQ-013 An issue SHALL be accepted on a cycle where issue_valid and issue_ready are both 1; op, rd and operands are captured on that edge, and inputs on any other cycle are ignored.
REQ-014 States SHALL be IDLE, SHIFT, MUL and WB.
- issue_ready=1 in IDLE and in WB; 0 in SHIFT and MUL.
- busy=1 in SHIFT and MUL only.
REQ-015 Ops 0-6 and the undefined ops SHALL go from accept to WB on the next edge, giving a latency of 1 cycle.
REQ-016 A shift SHALL use shamt=src2_dat[3:0].
- shamt=0: go straight to WB with the result equal to src1.
- Otherwise: shift one bit per cycle in SHIFT, then go to WB, giving a latency of shamt+1 cycles.
- SRA replicates bit 15.
REQ-017 MUL SHALL use shift-add over 16 SHIFT-free iterations in the MUL state, then go to WB, giving a latency of 17 cycles.
- The iteration counter is 4 bits and wraps 15->0 to terminate.
- Overflow above bit 15 is discarded.
REQ-018 In WB, wb_dat and wb_tgt SHALL hold the result and the captured rd, and wb_we=1 for exactly that cycle.
REQ-019 Outside WB, wb_we SHALL be 0; wb_dat and wb_tgt hold their last values.
REQ-020 wb_we SHALL be suppressed when rd=0; the state still passes through WB with the same timing.
REQ-021 An issue accepted in WB SHALL start the next operation back-to-back; WB with no issue returns to IDLE.
REQ-022 Undefined ops SHALL write result 0 with 1-cycle latency.
REQ-023 ADD and SUB SHALL wrap modulo 2^16.

Reset
REQ-024 With rst=1 at an edge:
- state goes to IDLE;
- wb_we=0, wb_dat=0, wb_tgt=0, busy=0, counters 0;
- any in-flight operation is discarded with no write-back.
REQ-025 issue_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-026 Macro EXEC_MUL_EN SHALL control the multiplier.
- Defined: MUL per REQ-017.
- Undefined: no MUL state or multiplier logic exists, and op 10 behaves as undefined per REQ-022.

Structure
REQ-027 A shared package SHALL hold the opcode enum, state enum, XLEN and RAW constants, for use by this block and the decoder.
REQ-028 Sub-module alu_comb SHALL implement the combinational single-cycle ops 0-6.
REQ-029 The exec_unit SHALL hold the FSM, shifter, multiplier and write-back registers.

Verification
REQ-030 ADD: src1=0x7FFF, src2=0x0001, rd=3 -> one cycle later wb_we=1, wb_tgt=3, wb_dat=0x8000.
REQ-031 SRA: src1=0x8000, src2=0x0004, rd=5 -> wb_dat=0xF800 after 5 cycles; busy=1 and issue_ready=0 for 4 cycles before WB.
REQ-032 MUL (EXEC_MUL_EN defined): 0x0123*0x0010, rd=7 -> wb_dat=0x1230 after 17 cycles; without the macro, op 10 -> wb_dat=0 after 1 cycle.
REQ-033 Write-back suppression: SLTU 0x0001<0xFFFF with rd=0 -> WB cycle occurs with wb_we=0.
REQ-034 Back-to-back: issue held valid with XOR 0x00FF^0x0F0F (rd=1) then OR 0x0001|0x0002 (rd=2) -> wb_dat=0x0FF0 then 0x0003 on consecutive cycles.
REQ-035 Reset mid-MUL: rst at iteration 8 -> no wb_we pulse, state IDLE, outputs 0 on the next cycle.
